// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: operation encodings
// and the default busy-period lengths.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // True for the four operations that occupy the unit for a busy period.
    function automatic logic is_md_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_unit.sv
// Multiply/divide unit with architectural HI/LO. The result is computed at the
// start edge and committed after a fixed busy period that mimics a real divider.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] MDU_A,
    input  logic [31:0] MDU_B,
    output logic        busy,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out,
    output logic [31:0] MDU_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [31:0]      hi, lo, hi_tmp, lo_tmp;
    logic [CNT_W-1:0] cnt;

    logic        op_signed, a_neg, b_neg, div_zero;
    logic [31:0] a_mag, b_mag, divisor, uq, ur;
    logic [63:0] mul_a, mul_b, prod;
    logic [31:0] hi_res, lo_res;

    // One shared multiplier and one shared unsigned divider; signed forms are
    // handled by sign extension (multiply) and magnitude/sign fix-up (divide).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        hi_res    = hi;
        lo_res    = lo;
        op_signed = (MDUOp == MDU_MULT) || (MDUOp == MDU_DIV);
        a_neg     = op_signed && MDU_A[31];
        b_neg     = op_signed && MDU_B[31];
        a_mag     = a_neg ? -MDU_A : MDU_A;
        b_mag     = b_neg ? -MDU_B : MDU_B;
        div_zero  = (MDU_B == 32'd0);
        divisor   = div_zero ? 32'd1 : b_mag;
        uq        = a_mag / divisor;
        ur        = a_mag % divisor;
        mul_a     = {{32{a_neg}}, MDU_A};
        mul_b     = {{32{b_neg}}, MDU_B};
        prod      = mul_a * mul_b;

        case (MDUOp)
            MDU_MULT, MDU_MULTU: begin
                hi_res = prod[63:32];
                lo_res = prod[31:0];
            end
            MDU_DIV, MDU_DIVU: begin
                // A zero divisor re-commits the current HI/LO, i.e. no change.
                if (!div_zero) begin
                    lo_res = (a_neg ^ b_neg) ? -uq : uq;
                    hi_res = a_neg ? -ur : ur;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi     <= '0;
            lo     <= '0;
            hi_tmp <= '0;
            lo_tmp <= '0;
            cnt    <= '0;
        end else if (cnt != '0) begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values of the others.
            if (cnt == CNT_W'(1)) begin
                hi  <= hi_tmp;
                lo  <= lo_tmp;
                cnt <= '0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end else if (!req) begin
            // A flushed E instruction (req=1) never reaches this branch.
            if (start && is_md_op(MDUOp)) begin
                hi_tmp <= hi_res;
                lo_tmp <= lo_res;
                cnt    <= ((MDUOp == MDU_MULT) || (MDUOp == MDU_MULTU))
                          ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            end else if (MDUOp == MDU_MTHI) begin
                hi <= MDU_A;
            end else if (MDUOp == MDU_MTLO) begin
                lo <= MDU_A;
            end
        end
    end

    assign busy   = (cnt != '0);
    assign HI_out = hi;
    assign LO_out = lo;

    always_comb begin
        case (MDUOp)
            MDU_MFHI: MDU_out = hi;
            MDU_MFLO: MDU_out = lo;
            default:  MDU_out = '0;
        endcase
    end

endmodule
